// File: rtl/anubis_pkg.sv
// Shared types for the March C- self-test: FSM states, data patterns and the
// per-element march table.
package anubis_pkg;

  typedef enum logic [3:0] {
    IDLE,
    W0_UP,
    R0W1_UP,
    R1W0_UP,
    R0W1_DN,
    R1W0_DN,
    R0_DN,
    PASS_END,
    HALT
  } state_t;

  // One-bit pattern seeds, replicated to DATA_W where used.
  localparam logic PAT0 = '0;
  localparam logic PAT1 = '1;

  // act: march element, dn: descending, rd: has read phase, ebit: expected
  // pattern, wr: writes, wbit: written pattern.
  typedef struct packed {
    logic act;
    logic dn;
    logic rd;
    logic ebit;
    logic wr;
    logic wbit;
  } elem_t;

  function automatic elem_t elem_of(state_t s);
    case (s)
      W0_UP:   return '{1'b1, 1'b0, 1'b0, PAT0, 1'b1, PAT0};
      R0W1_UP: return '{1'b1, 1'b0, 1'b1, PAT0, 1'b1, PAT1};
      R1W0_UP: return '{1'b1, 1'b0, 1'b1, PAT1, 1'b1, PAT0};
      R0W1_DN: return '{1'b1, 1'b1, 1'b1, PAT0, 1'b1, PAT1};
      R1W0_DN: return '{1'b1, 1'b1, 1'b1, PAT1, 1'b1, PAT0};
      R0_DN:   return '{1'b1, 1'b1, 1'b1, PAT0, 1'b0, PAT0};
      default: return '0;
    endcase
  endfunction

  function automatic state_t next_state(state_t s);
    case (s)
      W0_UP:   return R0W1_UP;
      R0W1_UP: return R1W0_UP;
      R1W0_UP: return R0W1_DN;
      R0W1_DN: return R1W0_DN;
      R1W0_DN: return R0_DN;
      default: return PASS_END;
    endcase
  endfunction

endpackage

// File: rtl/anubis_bist_ram.sv
// Single-port synchronous RAM with 1-cycle read latency and an optional
// stuck-at-0 fault on bit 0 of one address.
module bist_ram #(
  parameter int unsigned       ADDR_W       = 8,
  parameter int unsigned       DATA_W       = 8,
  parameter int unsigned       INJECT_FAULT = 0,
  parameter logic [ADDR_W-1:0] FAULT_ADDR   = ADDR_W'(8'h5A)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_c;

  // Fault sits on the read path so whatever was written, bit 0 reads back 0.
  always_comb begin
    rd_c = mem[addr];
    if (INJECT_FAULT != 0 && addr == FAULT_ADDR) rd_c[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= rd_c;
  end

endmodule

// File: rtl/anubis_top.sv
// Continuous March C- self-test of the internal RAM; results are held in
// status registers probed hierarchically.
module anubis_top #(
  parameter int unsigned       ADDR_W       = 8,
  parameter int unsigned       DATA_W       = 8,
  parameter int unsigned       MAX_PASSES   = 0,
  parameter int unsigned       INJECT_FAULT = 0,
  parameter logic [ADDR_W-1:0] FAULT_ADDR   = ADDR_W'(8'h5A)
) (
  input logic clk,
  input logic rst
);
  import anubis_pkg::*;

  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

  state_t              state;
  logic [ADDR_W-1:0]   addr;
  logic                phase;
  logic [15:0]         pass_count;
  logic [15:0]         err_count;
  logic                fail;
  logic                done;
  logic [ADDR_W-1:0]   last_err_addr;

  elem_t               el_c;
  logic                we_c;
  logic                last_c;
  logic                mism_c;
  logic [DATA_W-1:0]   wdata_c;
  logic [DATA_W-1:0]   exp_c;
  logic [DATA_W-1:0]   rdata;

  // RAM controls decode straight from the current element and phase.
  always_comb begin
    el_c    = elem_of(state);
    we_c    = el_c.act & el_c.wr & (phase | ~el_c.rd);
    wdata_c = {DATA_W{el_c.wbit}};
    exp_c   = {DATA_W{el_c.ebit}};
    last_c  = el_c.dn ? (addr == '0) : (addr == ADDR_MAX);
    mism_c  = el_c.act & el_c.rd & phase & (rdata != exp_c);
  end

  bist_ram #(
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .INJECT_FAULT(INJECT_FAULT),
    .FAULT_ADDR  (FAULT_ADDR)
  ) u_ram (
    .clk  (clk),
    .we   (we_c),
    .addr (addr),
    .wdata(wdata_c),
    .rdata(rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      addr          <= '0;
      phase         <= 1'b0;
      pass_count    <= '0;
      err_count     <= '0;
      fail          <= 1'b0;
      done          <= 1'b0;
      last_err_addr <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          state <= W0_UP;
          addr  <= '0;
          phase <= 1'b0;
        end
        PASS_END: begin
          pass_count <= pass_count + 16'd1;
          done       <= 1'b1;
          addr       <= '0;
          phase      <= 1'b0;
          if (MAX_PASSES != 0 && (pass_count + 16'd1) == 16'(MAX_PASSES))
            state <= HALT;
          else
            state <= W0_UP;
        end
        HALT: ;
        default: begin
          // March element: phase A issues the read, phase B checks/writes/steps.
          if (el_c.rd && !phase) begin
            phase <= 1'b1;
          end else begin
            phase <= 1'b0;
            if (mism_c) begin
              if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
              fail          <= 1'b1;
              last_err_addr <= addr;
            end
            if (last_c) begin
              state <= next_state(state);
              addr  <= elem_of(next_state(state)).dn ? ADDR_MAX : '0;
            end else begin
              addr  <= el_c.dn ? addr - ADDR_W'(1) : addr + ADDR_W'(1);
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_anubis_top.sv
// Bench for anubis_top: four parameterisations checked against an arithmetic
// model of the March C- schedule, plus a randomly timed mid-pass reset.
module tb_anubis_top;
  import anubis_pkg::*;

  logic clk = 1'b0;
  logic rst_d;
  logic rst_g;

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int t_d = -2;
  int t_g = -2;
  int flt_dones = 0;
  int max_dones = 0;
  bit max_moved = 1'b0;
  logic [31:0] flt_err3, flt_fail3, flt_last3;
  state_t rw_order [5] = '{R0W1_UP, R1W0_UP, R0W1_DN, R1W0_DN, R0_DN};

  anubis_top u_def (.clk(clk), .rst(rst_d));
  anubis_top #(.INJECT_FAULT(1), .FAULT_ADDR(8'h5A)) u_flt (.clk(clk), .rst(rst_g));
  anubis_top #(.MAX_PASSES(2)) u_max (.clk(clk), .rst(rst_g));
  anubis_top #(.ADDR_W(4)) u_sm (.clk(clk), .rst(rst_g));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected state/addr/done t cycles after entering W0_UP, from pass arithmetic.
  task automatic check_walk(input string who, input int t, input int aw, input state_t st,
                            input logic [31:0] ad, input logic dn);
    int n, plen, p, q, e, i, a;
    state_t s;
    bit has_a;
    n = 1 << aw;
    plen = 11 * n + 1;
    p = t % plen;
    has_a = 1'b1;
    if (p < n) begin
      s = W0_UP;
      a = p;
    end else if (p < 11 * n) begin
      q = p - n;
      e = q / (2 * n);
      i = (q % (2 * n)) / 2;
      s = rw_order[e];
      a = (e >= 2) ? n - 1 - i : i;
    end else begin
      s = PASS_END;
      a = 0;
      has_a = 1'b0;
    end
    chk({who, "_state"}, 32'(st), 32'(s));
    if (has_a) chk({who, "_addr"}, ad, 32'(a));
    chk({who, "_done"}, 32'(dn), 32'(t > 0 && p == 0));
  endtask

  task automatic step();
    @(negedge clk);
    if (t_d != -2) t_d++;
    if (t_g != -2) t_g++;
    if (t_d >= 0) check_walk("def", t_d, 8, u_def.state, 32'(u_def.addr), u_def.done);
    if (t_g >= 0 && t_g <= 400) check_walk("sm", t_g, 4, u_sm.state, 32'(u_sm.addr), u_sm.done);
    if (t_g >= 0 && u_flt.done) begin
      flt_dones++;
      chk("flt_err_per_pass", 32'(u_flt.err_count), 32'(2 * flt_dones));
      chk("flt_pass_count", 32'(u_flt.pass_count), 32'(flt_dones));
      if (flt_dones == 3) begin
        flt_err3  = 32'(u_flt.err_count);
        flt_fail3 = 32'(u_flt.fail);
        flt_last3 = 32'(u_flt.last_err_addr);
      end
    end
    if (t_g >= 0 && u_max.done) max_dones++;
    if (max_dones >= 2 && (u_max.pass_count != 16'd2 || u_max.state != HALT)) max_moved = 1'b1;
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_state"}, 32'(u_def.state), 32'(IDLE));
    chk({tag, "_addr"}, 32'(u_def.addr), 32'd0);
    chk({tag, "_pass"}, 32'(u_def.pass_count), 32'd0);
    chk({tag, "_err"}, 32'(u_def.err_count), 32'd0);
    chk({tag, "_fail"}, 32'(u_def.fail), 32'd0);
    chk({tag, "_done"}, 32'(u_def.done), 32'd0);
    chk({tag, "_last"}, 32'(u_def.last_err_addr), 32'd0);
  endtask

  initial begin
    int k;
    int target;
    flt_err3 = '0;
    flt_fail3 = '0;
    flt_last3 = '0;

    // Reset hold, then release.
    rst_d = 1'b0;
    rst_g = 1'b0;
    repeat (5) @(negedge clk);
    chk_cleared("rst");
    chk("rst_sm_state", 32'(u_sm.state), 32'(IDLE));
    rst_d = 1'b1;
    rst_g = 1'b1;
    t_d = -1;
    t_g = -1;
    #1;
    chk("release_idle", 32'(u_def.state), 32'(IDLE));
    step();
    chk("release_w0", 32'(u_def.state), 32'(W0_UP));

    // First pass of the default instance.
    k = 0;
    while (!u_def.done && k < 3000) begin
      step();
      k++;
    end
    chk("first_done_t", 32'(t_d), 32'd2817);
    chk("first_pass", 32'(u_def.pass_count), 32'd1);
    chk("first_err", 32'(u_def.err_count), 32'd0);
    chk("first_fail", 32'(u_def.fail), 32'd0);

    // Asynchronous reset at a random point inside R1W0_DN of pass 2.
    target = 2817 + $urandom_range(2303, 1792);
    while (t_d < target) step();
    chk("mid_in_r1w0dn", 32'(u_def.state), 32'(R1W0_DN));
    #2;
    rst_d = 1'b0;
    t_d = -2;
    #1;
    chk_cleared("async");
    repeat ($urandom_range(4, 1)) step();
    rst_d = 1'b1;
    t_d = -1;
    step();
    chk("rerun_w0", 32'(u_def.state), 32'(W0_UP));
    k = 0;
    while (!u_def.done && k < 3000) begin
      step();
      k++;
    end
    chk("rerun_done_t", 32'(t_d), 32'd2817);
    chk("rerun_pass", 32'(u_def.pass_count), 32'd1);
    chk("rerun_err", 32'(u_def.err_count), 32'd0);

    // Fault instance after three passes (snapshot taken at the third done).
    while (t_g < 3 * 2817) step();
    chk("flt_dones", 32'(flt_dones), 32'd3);
    chk("flt_err3", flt_err3, 32'd6);
    chk("flt_fail3", flt_fail3, 32'd1);
    chk("flt_last3", flt_last3, 32'h5A);

    // MAX_PASSES=2 instance halts and stays frozen for 10000 cycles.
    while (t_g < 2 * 2817 + 10000) step();
    chk("max_dones", 32'(max_dones), 32'd2);
    chk("max_state", 32'(u_max.state), 32'(HALT));
    chk("max_pass", 32'(u_max.pass_count), 32'd2);
    chk("max_err", 32'(u_max.err_count), 32'd0);
    chk("max_stable", 32'(max_moved), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
